// File: rtl/conv_ctl_pkg.sv
// Shared types and helpers for the convolution window sequencer:
// FSM state encoding, tap-count function and tap-to-bit mapping.
package conv_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } conv_state_t;

    function automatic int kn_of(input int k);
        return k * k;
    endfunction

    // Tap 0 (top-left) lives in the most significant slot of mask and data.
    function automatic int tap_bit(input int tap, input int kn);
        return kn - 1 - tap;
    endfunction

endpackage

// File: rtl/conv_win_fifo.sv
// First-word-fall-through FIFO holding aligned windows {first, mask, taps}.
// Writes into a full FIFO are dropped and flagged by an assertion.
module conv_win_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks a KxK window over an H x W map, issues window reads and hands padded,
// masked taps to the PE array. Define CONV_PAD_VALUE_EN for a programmable pad byte.
module conv_window_sequencer
    import conv_ctl_pkg::*;
#(
    parameter int  DW         = 8,
    parameter int  K          = 3,
    parameter int  BW         = 16,
    parameter int  BN         = 8,
    parameter int  CW         = 8,
    parameter int  MEM_LAT    = 1,
    parameter int  OBUF_DEPTH = 4,
    localparam int KN         = kn_of(K)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CW-1:0]       cfg_w,
    input  logic [CW-1:0]       cfg_h,
    input  logic                cfg_pad,
    input  logic [BN*BW-1:0]    bias_in,
`ifdef CONV_PAD_VALUE_EN
    input  logic [DW-1:0]       pad_val,
`endif
    output logic                busy,
    output logic                done,
    output logic                rd_req,
    output logic [CW-1:0]       rd_row,
    output logic [CW-1:0]       rd_col,
    input  logic [KN*DW-1:0]    rd_data,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [KN*DW-1:0]    win_data,
    output logic [KN-1:0]       win_mask,
    output logic                bias_vld,
    output logic [BN*BW-1:0]    bias_out
);

    // state    | meaning
    // ST_IDLE  | waiting for start; empty frames finish here with a done pulse
    // ST_RUN   | issuing one window read per cycle while credits remain
    // ST_DRAIN | all reads issued; waiting for returns and buffer to empty

    localparam int             HALF     = K / 2;
    localparam int             CRW      = $clog2(OBUF_DEPTH + 1);
    localparam int             FW       = KN * DW + KN + 1;
    localparam logic [CW-1:0]  HALF_C   = CW'(HALF);
    localparam logic [CW-1:0]  K_C      = CW'(K);
    localparam logic [CRW-1:0] CRED_MAX = CRW'(OBUF_DEPTH);

    conv_state_t          state_q;
    conv_state_t          state_d;
    logic [CW-1:0]        w_q;
    logic [CW-1:0]        h_q;
    logic                 pad_q;
    logic [BN*BW-1:0]     bias_q;
    logic [CW-1:0]        row_q;
    logic [CW-1:0]        col_q;
    logic                 first_q;
    logic                 done_empty_q;
    logic [CRW-1:0]       credits_q;

    logic                 start_acc;
    logic                 cfg_empty;
    logic                 issue;
    logic                 pop;
    logic                 last_pos;
    logic                 drain_done;
    logic [CW-1:0]        scan_first;
    logic [CW-1:0]        col_end;
    logic [CW-1:0]        row_end;
    logic [DW-1:0]        pad_fill;

    logic [KN-1:0]        mask_c;
    logic signed [CW+1:0] pos_r;
    logic signed [CW+1:0] pos_c;

    logic [MEM_LAT-1:0]   pipe_vld;
    logic [MEM_LAT-1:0]   pipe_first;
    logic [KN-1:0]        pipe_mask [MEM_LAT];
    logic [KN*DW-1:0]     pad_data;

    logic                 fifo_empty;
    logic [FW-1:0]        fifo_wr_data;
    logic [FW-1:0]        fifo_rd_data;
    logic                 out_first;
    logic [KN-1:0]        out_mask;
    logic [KN*DW-1:0]     out_data;

    assign start_acc  = (state_q == ST_IDLE) && start;
    assign cfg_empty  = (cfg_w == '0) || (cfg_h == '0) ||
                        (!cfg_pad && ((cfg_w < K_C) || (cfg_h < K_C)));
    assign scan_first = pad_q ? '0 : HALF_C;
    assign col_end    = pad_q ? (w_q - CW'(1)) : (w_q - CW'(1) - HALF_C);
    assign row_end    = pad_q ? (h_q - CW'(1)) : (h_q - CW'(1) - HALF_C);
    assign issue      = (state_q == ST_RUN) && (credits_q != '0);
    assign pop        = win_valid && win_ready;
    assign last_pos   = (row_q == row_end) && (col_q == col_end);
    assign drain_done = (state_q == ST_DRAIN) && (pipe_vld == '0) && fifo_empty;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = done_empty_q;
        rd_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !cfg_empty) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy   = 1'b1;
                rd_req = issue;
                if (issue && last_pos) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_done) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            w_q          <= '0;
            h_q          <= '0;
            pad_q        <= 1'b0;
            bias_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            first_q      <= 1'b0;
            done_empty_q <= 1'b0;
            credits_q    <= CRED_MAX;
        end else begin
            state_q      <= state_d;
            done_empty_q <= start_acc && cfg_empty;
            credits_q    <= credits_q + CRW'(pop) - CRW'(issue);
            if (start_acc) begin
                w_q     <= cfg_w;
                h_q     <= cfg_h;
                pad_q   <= cfg_pad;
                bias_q  <= bias_in;
                first_q <= 1'b1;
                row_q   <= cfg_pad ? '0 : HALF_C;
                col_q   <= cfg_pad ? '0 : HALF_C;
            end else if (issue) begin
                first_q <= 1'b0;
                if (col_q == col_end) begin
                    col_q <= scan_first;
                    row_q <= row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    assign rd_row = row_q;
    assign rd_col = col_q;

    // Two guard bits keep r+K/2 from wrapping at the top of the counter range.
    always_comb begin
        mask_c = '0;
        pos_r  = '0;
        pos_c  = '0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                pos_r = $signed({2'b00, row_q}) + $signed((CW+2)'(ky - HALF));
                pos_c = $signed({2'b00, col_q}) + $signed((CW+2)'(kx - HALF));
                mask_c[tap_bit(ky * K + kx, KN)] = !pad_q ||
                    (!pos_r[CW+1] && (pos_r < $signed({2'b00, h_q})) &&
                     !pos_c[CW+1] && (pos_c < $signed({2'b00, w_q})));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld   <= '0;
            pipe_first <= '0;
            for (int i = 0; i < MEM_LAT; i++) pipe_mask[i] <= '0;
        end else begin
            pipe_vld[0]   <= issue;
            pipe_first[0] <= issue && first_q;
            pipe_mask[0]  <= mask_c;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i]   <= pipe_vld[i-1];
                pipe_first[i] <= pipe_first[i-1];
                pipe_mask[i]  <= pipe_mask[i-1];
            end
        end
    end

`ifdef CONV_PAD_VALUE_EN
    logic [DW-1:0] pad_val_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         pad_val_q <= '0;
        else if (start_acc) pad_val_q <= pad_val;
    end

    assign pad_fill = pad_val_q;
`else
    assign pad_fill = '0;
`endif

    always_comb begin
        pad_data = rd_data;
        for (int b = 0; b < KN; b++) begin
            if (!pipe_mask[MEM_LAT-1][b]) pad_data[b*DW +: DW] = pad_fill;
        end
    end

    assign fifo_wr_data = {pipe_first[MEM_LAT-1], pipe_mask[MEM_LAT-1], pad_data};

    conv_win_fifo #(
        .WIDTH (FW),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pipe_vld[MEM_LAT-1]),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign {out_first, out_mask, out_data} = fifo_rd_data;

    assign win_valid = !fifo_empty;
    assign win_data  = win_valid ? out_data : '0;
    assign win_mask  = win_valid ? out_mask : '0;
    assign bias_vld  = win_valid && out_first;
    assign bias_out  = bias_vld ? bias_q : '0;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer (K=3, MEM_LAT=3, OBUF_DEPTH=2).
// Builds with or without CONV_PAD_VALUE_EN; expected pad byte follows the build.
module tb_conv_window_sequencer;

    localparam int DW = 8, K = 3, KN = 9, BW = 16, BN = 8, CW = 8;
    localparam int MEM_LAT = 3, OBUF_DEPTH = 2;
`ifdef CONV_PAD_VALUE_EN
    localparam logic [7:0] PADV = 8'h80;
`else
    localparam logic [7:0] PADV = 8'h00;
`endif
    localparam logic [127:0] BIAS_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] BIAS_B = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     cfg_w = '0;
    logic [CW-1:0]     cfg_h = '0;
    logic              cfg_pad = 1'b0;
    logic [127:0]      bias_in = '0;
`ifdef CONV_PAD_VALUE_EN
    logic [7:0]        pad_val = 8'h80;
`endif
    logic              busy, done, rd_req, win_valid, bias_vld;
    logic              win_ready = 1'b1;
    logic [CW-1:0]     rd_row, rd_col;
    logic [KN*DW-1:0]  rd_data, win_data;
    logic [KN-1:0]     win_mask;
    logic [127:0]      bias_out;

    int total = 0;
    int bad = 0;
    int cur_w = 0, cur_h = 0;

    logic [71:0]  got_d [64];
    logic [8:0]   got_m [64];
    logic         got_b [64];
    logic [127:0] got_bo[64];
    logic [71:0]  ref_d [64];
    logic [8:0]   ref_m [64];

    always #5 clk = ~clk;

    conv_window_sequencer #(
        .DW(DW), .K(K), .BW(BW), .BN(BN), .CW(CW),
        .MEM_LAT(MEM_LAT), .OBUF_DEPTH(OBUF_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_pad(cfg_pad), .bias_in(bias_in),
`ifdef CONV_PAD_VALUE_EN
        .pad_val(pad_val),
`endif
        .busy(busy), .done(done), .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_mask(win_mask), .bias_vld(bias_vld), .bias_out(bias_out)
    );

    function automatic logic [7:0] pix(input int r, input int c);
        logic [3:0] a, b;
        a = 4'(r + 1);
        b = 4'(c + 1);
        return {a, b};
    endfunction

    // Out-of-bounds taps come back from memory as 8'hEE so padding is visible.
    function automatic logic [71:0] mem_window(input int r, input int c, input int w, input int h);
        logic [71:0] d;
        int pr, pc, b;
        d = '0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
                pr = r - 1 + ky; pc = c - 1 + kx; b = 8 - (ky * 3 + kx);
                d[b*8 +: 8] = (pr >= 0 && pr < h && pc >= 0 && pc < w) ? pix(pr, pc) : 8'hEE;
            end
        return d;
    endfunction

    task automatic exp_win(input int r, input int c, input int w, input int h,
                           output logic [71:0] d, output logic [8:0] m);
        int pr, pc, b;
        d = '0; m = '0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
                pr = r - 1 + ky; pc = c - 1 + kx; b = 8 - (ky * 3 + kx);
                if (pr >= 0 && pr < h && pc >= 0 && pc < w) begin
                    m[b] = 1'b1; d[b*8 +: 8] = pix(pr, pc);
                end else begin
                    d[b*8 +: 8] = PADV;
                end
            end
    endtask

    logic [71:0] mem_pipe [MEM_LAT];
    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
        mem_pipe[0] <= rd_req ? mem_window(int'(rd_row), int'(rd_col), cur_w, cur_h) : {9{8'hA5}};
    end
    assign rd_data = mem_pipe[MEM_LAT-1];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Runs one frame from posedge+1; records accepted windows into got_*.
    task automatic run_frame(input int w, input int h, input logic pad, input logic stall,
                             input logic inject, input logic [127:0] bias,
                             output int nwin, output int ndone, output int lat);
        int first_req, first_val, tail, outst, max_out, unstable;
        logic was_stall;
        logic [71:0] prev_d;
        logic [8:0] prev_m;
        nwin = 0; ndone = 0; first_req = -1; first_val = -1; tail = -1;
        outst = 0; max_out = 0; unstable = 0; was_stall = 1'b0; prev_d = '0; prev_m = '0;
        cur_w = w; cur_h = h;
        cfg_w = CW'(w); cfg_h = CW'(h); cfg_pad = pad; bias_in = bias; start = 1'b1; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_w = 8'hFF; cfg_h = 8'hFF; bias_in = ~bias;
`ifdef CONV_PAD_VALUE_EN
        pad_val = 8'h11;
`endif
        for (int cyc = 0; cyc < 600 && tail != 0; cyc++) begin
            win_ready = stall ? (((cyc / 3) % 2) == 1) : 1'b1;
            start = inject && (cyc == 6);
            @(negedge clk);
            if (rd_req) begin
                outst++;
                if (first_req < 0) first_req = cyc;
            end
            if (win_valid && first_val < 0) first_val = cyc;
            if (was_stall && (win_data !== prev_d || win_mask !== prev_m)) unstable++;
            was_stall = win_valid && !win_ready;
            prev_d = win_data; prev_m = win_mask;
            if (win_valid && win_ready) begin
                if (nwin < 64) begin
                    got_d[nwin] = win_data; got_m[nwin] = win_mask;
                    got_b[nwin] = bias_vld; got_bo[nwin] = bias_out;
                end
                nwin++; outst--;
            end
            if (outst > max_out) max_out = outst;
            if (done) begin
                ndone++;
                if (tail < 0) tail = 3;
            end
            if (tail > 0) tail--;
            @(posedge clk); #1;
        end
        start = 1'b0; win_ready = 1'b1;
        lat = first_val - first_req;
        chk("frame_finished", 128'(tail == 0), 128'd1);
        chk("credit_bound", 128'(max_out <= OBUF_DEPTH), 128'd1);
        chk("stall_stable", 128'(unstable), 128'd0);
        chk("busy_after_frame", 128'(busy), 128'd0);
`ifdef CONV_PAD_VALUE_EN
        pad_val = 8'h80;
`endif
    endtask

    task automatic check_windows(input string tag, input int w, input int h, input logic pad,
                                 input logic [127:0] bias, input int nwin);
        logic [71:0] d;
        logic [8:0] m;
        int r, c, n;
        n = (nwin < 64) ? nwin : 64;
        for (int i = 0; i < n; i++) begin
            r = pad ? i / w : 1 + i / (w - 2);
            c = pad ? i % w : 1 + i % (w - 2);
            exp_win(r, c, w, h, d, m);
            chk($sformatf("%s_data%0d", tag, i), 128'(got_d[i]), 128'(d));
            chk($sformatf("%s_mask%0d", tag, i), 128'(got_m[i]), 128'(m));
            chk($sformatf("%s_bvld%0d", tag, i), 128'(got_b[i]), 128'(i == 0));
            chk($sformatf("%s_bias%0d", tag, i), got_bo[i], (i == 0) ? bias : 128'd0);
        end
    endtask

    initial begin
        int nwin, ndone, lat, req_seen, busy_seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_rd_req", 128'(rd_req), 128'd0);
        chk("rst_win_valid", 128'(win_valid), 128'd0);
        chk("rst_bias_vld", 128'(bias_vld), 128'd0);
        chk("rst_rowcol", 128'({rd_row, rd_col}), 128'd0);
        chk("rst_win", 128'({win_data, win_mask}), 128'd0);
        chk("rst_bias_out", bias_out, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x4 same padding, free-flowing output
        run_frame(4, 4, 1'b1, 1'b0, 1'b0, BIAS_A, nwin, ndone, lat);
        chk("a_count", 128'(nwin), 128'd16);
        chk("a_done_once", 128'(ndone), 128'd1);
        chk("a_latency", 128'(lat), 128'(MEM_LAT + 1));
        chk("a_first_mask", 128'(got_m[0]), 128'(9'b000_011_011));
        chk("a_last_mask", 128'(got_m[15]), 128'(9'b110_110_000));
        chk("a_centre_mask", 128'(got_m[5]), 128'(9'h1FF));
        chk("a_first_data", 128'(got_d[0]),
            128'({PADV, PADV, PADV, PADV, 8'h11, 8'h12, PADV, 8'h21, 8'h22}));
        chk("a_last_data", 128'(got_d[15]),
            128'({8'h33, 8'h34, PADV, 8'h43, 8'h44, PADV, PADV, PADV, PADV}));
        chk("a_first_bias", got_bo[0], BIAS_A);
        check_windows("a", 4, 4, 1'b1, BIAS_A, nwin);
        for (int i = 0; i < 16; i++) begin
            ref_d[i] = got_d[i];
            ref_m[i] = got_m[i];
        end

        // 4x4 valid padding
        run_frame(4, 4, 1'b0, 1'b0, 1'b0, BIAS_B, nwin, ndone, lat);
        chk("b_count", 128'(nwin), 128'd4);
        chk("b_done_once", 128'(ndone), 128'd1);
        chk("b_first_data", 128'(got_d[0]), 128'(72'h11_12_13_21_22_23_31_32_33));
        chk("b_last_data", 128'(got_d[3]), 128'(72'h22_23_24_32_33_34_42_43_44));
        chk("b_last_mask", 128'(got_m[3]), 128'(9'h1FF));
        check_windows("b", 4, 4, 1'b0, BIAS_B, nwin);

        // empty frame: 2x5 with valid padding
        cfg_w = 8'd2; cfg_h = 8'd5; cfg_pad = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("empty_done", 128'(done), 128'd1);
        chk("empty_busy", 128'(busy), 128'd0);
        req_seen = 0; busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("empty_done_single", 128'(done), 128'd0);
            if (rd_req) req_seen++;
            if (busy) busy_seen++;
        end
        chk("empty_no_req", 128'(req_seen), 128'd0);
        chk("empty_no_busy", 128'(busy_seen), 128'd0);

        // stalled consumer must yield the same sequence
        run_frame(4, 4, 1'b1, 1'b1, 1'b0, BIAS_A, nwin, ndone, lat);
        chk("c_count", 128'(nwin), 128'd16);
        chk("c_done_once", 128'(ndone), 128'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("c_same_data%0d", i), 128'(got_d[i]), 128'(ref_d[i]));
            chk($sformatf("c_same_mask%0d", i), 128'(got_m[i]), 128'(ref_m[i]));
        end
        check_windows("c", 4, 4, 1'b1, BIAS_A, nwin);

        // start pulsed mid-frame is ignored
        run_frame(4, 4, 1'b1, 1'b0, 1'b1, BIAS_B, nwin, ndone, lat);
        chk("d_count", 128'(nwin), 128'd16);
        chk("d_done_once", 128'(ndone), 128'd1);
        check_windows("d", 4, 4, 1'b1, BIAS_B, nwin);

        // reset in the middle of a frame
        cur_w = 4; cur_h = 4;
        cfg_w = 8'd4; cfg_h = 8'd4; cfg_pad = 1'b1; bias_in = BIAS_A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy_before_rst", 128'(busy), 128'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ctl", 128'({busy, done, rd_req, win_valid, bias_vld}), 128'd0);
        chk("mid_rst_rowcol", 128'({rd_row, rd_col}), 128'd0);
        chk("mid_rst_win", 128'({win_data, win_mask}), 128'd0);
        chk("mid_rst_bias", bias_out, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(4, 4, 1'b0, 1'b0, 1'b0, BIAS_B, nwin, ndone, lat);
        chk("e_count", 128'(nwin), 128'd4);
        chk("e_done_once", 128'(ndone), 128'd1);
        check_windows("e", 4, 4, 1'b0, BIAS_B, nwin);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
